// File: rtl/ttm4_ctrl_pkg.sv
// Shared state encoding for the TTM4 run/halt/step sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ttm4_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_RESET = 3'd0,
        S_HALT  = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

endpackage

// File: rtl/ttm4_ce_prescaler.sv
// Run-mode prescaler: counts 0..DIV-1 while enabled and flags the terminal count.
// Latency: tc is combinational from the registered count.
// Backpressure: none; clr wins over en.
module ttm4_ce_prescaler #(
    parameter int DIV_W = 24,
    parameter int DIV   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ttm4_run_ctrl.sv
// Run/halt/single-step sequencer for the TTM4 core; optional PC breakpoint under TTM4_BREAKPOINT_EN.
// Latency: all outputs registered; a request is reflected one cycle after it is sampled.
// Backpressure: none; simultaneous requests resolve SRST > HALT > STEP > RUN, the rest are dropped.
module ttm4_run_ctrl
    import ttm4_ctrl_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int DIV_W      = 24,
    parameter int DIV        = 1,
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RUN_REQ,
    input  logic               HALT_REQ,
    input  logic               STEP_REQ,
    input  logic               SRST_REQ,
    input  logic [PC_W-1:0]    PC,
    input  logic [PC_W-1:0]    BRK_ADDR,
    input  logic               BRK_VALID,
    output logic               CPU_CE,
    output logic               CPU_RST,
    output logic               HALTED,
    output logic               BRK_HIT,
    output logic [STATE_W-1:0] STATE,
    output logic [CNT_W-1:0]   ICOUNT
);

    localparam int RCW = $clog2(RST_CYCLES) + 1;

    state_t           state, nextState;
    logic [RCW-1:0]   rstCnt;
    logic             srst, haltQ, stepQ, runQ;
    logic             tc, presClr, runCe, ceNext, brkMatch;

    assign srst  = SRST_REQ;
    assign haltQ = !srst && HALT_REQ;
    assign stepQ = !srst && !HALT_REQ && STEP_REQ;
    assign runQ  = !srst && !HALT_REQ && !STEP_REQ && RUN_REQ;

`ifdef TTM4_BREAKPOINT_EN
    logic skip;

    // The skip flag lets the resumed run execute the instruction it stopped on.
    assign brkMatch = BRK_VALID && (PC == BRK_ADDR) && !skip;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            skip <= 1'b0;
        end else if (srst) begin
            skip <= 1'b0;
        end else if (state == S_BRK && nextState == S_RUN) begin
            skip <= 1'b1;
        end else if (runCe || (state == S_HALT && nextState == S_RUN)) begin
            skip <= 1'b0;
        end
    end
`else
    logic unusedBrk;
    assign unusedBrk = ^{PC, BRK_ADDR, BRK_VALID};
    assign brkMatch  = 1'b0;
`endif

    ttm4_ce_prescaler #(
        .DIV_W (DIV_W),
        .DIV   (DIV)
    ) u_prescaler (
        .clk (CLK),
        .rst (RST),
        .clr (presClr),
        .en  (state == S_RUN),
        .tc  (tc)
    );

    always_comb begin
        nextState = state;
        runCe     = 1'b0;
        presClr   = 1'b0;
        case (state)
            S_RESET: if (rstCnt == RCW'(RST_CYCLES - 1)) nextState = S_HALT;
            S_HALT, S_BRK: begin
                if (stepQ) begin
                    nextState = S_STEP;
                end else if (runQ) begin
                    nextState = S_RUN;
                    presClr   = 1'b1;
                end
            end
            S_STEP: nextState = S_HALT;
            S_RUN: begin
                if (haltQ) begin
                    nextState = S_HALT;
                end else if (tc) begin
                    if (brkMatch) nextState = S_BRK;
                    else          runCe     = 1'b1;
                end
            end
            default: nextState = S_RESET;
        endcase
        if (srst) begin
            nextState = S_RESET;
            runCe     = 1'b0;
            presClr   = 1'b1;
        end
    end

    assign ceNext = runCe || (nextState == S_STEP);
    assign STATE  = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_RESET;
            rstCnt  <= '0;
            CPU_RST <= 1'b1;
            CPU_CE  <= 1'b0;
            HALTED  <= 1'b0;
            BRK_HIT <= 1'b0;
            ICOUNT  <= '0;
        end else begin
            state   <= nextState;
            rstCnt  <= (state == S_RESET && nextState == S_RESET && !srst) ? rstCnt + 1'b1 : '0;
            CPU_RST <= (nextState == S_RESET);
            CPU_CE  <= ceNext;
            HALTED  <= (nextState == S_HALT) || (nextState == S_BRK);
`ifdef TTM4_BREAKPOINT_EN
            BRK_HIT <= (nextState == S_BRK);
`else
            BRK_HIT <= 1'b0;
`endif
            if (srst) begin
                ICOUNT <= '0;
            end else if (ceNext && ICOUNT != '1) begin
                ICOUNT <= ICOUNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ttm4_run_ctrl.sv
// Directed bench for ttm4_run_ctrl with DIV=3, RST_CYCLES=4, CNT_W=4 and a CE-driven PC model.
module tb_ttm4_run_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RUN_REQ = 1'b0, HALT_REQ = 1'b0, STEP_REQ = 1'b0, SRST_REQ = 1'b0;
    logic [7:0] PC = 8'd0;
    logic [7:0] BRK_ADDR = 8'h05;
    logic       BRK_VALID = 1'b0;
    logic       CPU_CE, CPU_RST, HALTED, BRK_HIT;
    logic [2:0] STATE;
    logic [3:0] ICOUNT;

    int checks = 0;
    int errors = 0;
    int ceCnt  = 0;
    int snap;
    int n;

    ttm4_run_ctrl #(
        .PC_W(8), .DIV_W(24), .DIV(3), .CNT_W(4), .RST_CYCLES(4)
    ) dut (
        .CLK(CLK), .RST(RST), .RUN_REQ(RUN_REQ), .HALT_REQ(HALT_REQ),
        .STEP_REQ(STEP_REQ), .SRST_REQ(SRST_REQ), .PC(PC), .BRK_ADDR(BRK_ADDR),
        .BRK_VALID(BRK_VALID), .CPU_CE(CPU_CE), .CPU_RST(CPU_RST), .HALTED(HALTED),
        .BRK_HIT(BRK_HIT), .STATE(STATE), .ICOUNT(ICOUNT)
    );

    always #5 CLK = ~CLK;

    // CPU model: PC advances on every clock enable, clears while held in reset.
    always @(posedge CLK) begin
        if (CPU_CE) ceCnt++;
        if (CPU_RST) PC <= 8'd0;
        else if (CPU_CE) PC <= PC + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds the requests for exactly one posedge.
    task automatic pulse(input logic s, input logic h, input logic st, input logic r);
        SRST_REQ = s; HALT_REQ = h; STEP_REQ = st; RUN_REQ = r;
        @(negedge CLK);
        SRST_REQ = 0; HALT_REQ = 0; STEP_REQ = 0; RUN_REQ = 0;
    endtask

    task automatic countRst(output int cnt);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (CPU_RST) cnt++;
            @(negedge CLK);
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_cpu_rst", CPU_RST, 1);
        check("rst_ce", CPU_CE, 0);
        check("rst_halted", HALTED, 0);
        check("rst_brk_hit", BRK_HIT, 0);
        check("rst_icount", ICOUNT, 0);
        check("rst_state", STATE, 0);

        RST = 1'b0;
        countRst(n);
        check("rst_cycles", n, 4);
        check("post_rst_state", STATE, 1);
        check("post_rst_halted", HALTED, 1);

        // Free run at DIV=3 for 30 cycles
        snap = ceCnt;
        pulse(0, 0, 0, 1);
        check("run_state", STATE, 2);
        check("run_halted", HALTED, 0);
        repeat (2) @(negedge CLK);
        check("run_no_early_ce", ceCnt - snap, 0);
        @(negedge CLK);
        check("run_first_ce", CPU_CE, 1);
        @(negedge CLK);
        check("run_ce_one_cycle", CPU_CE, 0);
        repeat (26) @(negedge CLK);
        pulse(0, 1, 0, 0);
        check("run_ce_count", ceCnt - snap, 10);
        check("run_icount", ICOUNT, 10);
        check("halt_state", STATE, 1);
        repeat (10) @(negedge CLK);
        check("halt_no_ce", ceCnt - snap, 10);
        check("halt_icount", ICOUNT, 10);

        // Soft reset from halt clears the counter
        pulse(1, 0, 0, 0);
        check("srst_icount", ICOUNT, 0);
        check("srst_state", STATE, 0);
        countRst(n);
        check("srst_cycles", n, 4);
        check("srst_end_state", STATE, 1);

        // Three single steps, five cycles apart
        snap = ceCnt;
        for (int k = 0; k < 3; k++) begin
            pulse(0, 0, 1, 0);
            check("step_ce", CPU_CE, 1);
            check("step_state", STATE, 3);
            @(negedge CLK);
            check("step_ce_drop", CPU_CE, 0);
            check("step_back_halt", STATE, 1);
            repeat (3) @(negedge CLK);
        end
        check("step_ce_count", ceCnt - snap, 3);
        check("step_icount", ICOUNT, 3);

        // Simultaneous HALT/STEP/RUN in halt: HALT wins and does nothing
        snap = ceCnt;
        pulse(0, 1, 1, 1);
        check("prio_state", STATE, 1);
        check("prio_ce", CPU_CE, 0);
        repeat (6) @(negedge CLK);
        check("prio_no_ce", ceCnt - snap, 0);
        check("prio_icount", ICOUNT, 3);

        // Soft reset in the middle of a run at ICOUNT=7
        pulse(0, 0, 0, 1);
        repeat (12) @(negedge CLK);
        check("mid_icount", ICOUNT, 7);
        @(negedge CLK);
        snap = ceCnt;
        pulse(1, 0, 0, 0);
        check("mid_srst_state", STATE, 0);
        check("mid_srst_icount", ICOUNT, 0);
        check("mid_srst_ce", CPU_CE, 0);
        countRst(n);
        check("mid_srst_cycles", n, 4);
        check("mid_srst_end", STATE, 1);
        check("mid_srst_no_ce", ceCnt - snap, 0);

        // Breakpoint at PC 0x05
        BRK_VALID = 1'b1;
        snap = ceCnt;
        pulse(0, 0, 0, 1);
`ifdef TTM4_BREAKPOINT_EN
        for (int i = 0; i < 60 && STATE != 3'd4; i++) @(negedge CLK);
        check("brk_state", STATE, 4);
        check("brk_hit", BRK_HIT, 1);
        check("brk_halted", HALTED, 1);
        check("brk_icount", ICOUNT, 5);
        check("brk_pc", PC, 8'h05);
        check("brk_ce_count", ceCnt - snap, 5);
        pulse(0, 0, 0, 1);
        check("brk_resume_state", STATE, 2);
        check("brk_hit_clear", BRK_HIT, 0);
        repeat (3) @(negedge CLK);
        check("brk_resume_ce", CPU_CE, 1);
        check("brk_resume_icount", ICOUNT, 6);
        repeat (6) @(negedge CLK);
        check("brk_runs_on_icount", ICOUNT, 8);
        check("brk_runs_on_state", STATE, 2);
`else
        repeat (18) @(negedge CLK);
        check("nobrk_icount", ICOUNT, 6);
        check("nobrk_state", STATE, 2);
        check("nobrk_hit", BRK_HIT, 0);
`endif
        pulse(0, 1, 0, 0);
        BRK_VALID = 1'b0;

        // Saturation of the 4-bit counter
        snap = ceCnt;
        pulse(0, 0, 0, 1);
        repeat (40) @(negedge CLK);
        check("sat_ce_count", ceCnt - snap, 13);
        check("sat_icount", ICOUNT, 15);
        pulse(0, 1, 0, 0);
        check("sat_hold", ICOUNT, 15);
        check("sat_halt_state", STATE, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
